// File: rtl/mat_frame_loader.sv
// Serial-to-packed loader: assembles two 4x4 signed 16-bit matrices (A then B) from a word stream and holds the frame for downstream.
// Optional in_last framing check is enabled by defining MAT_FRAME_LOADER_CHK_EN.
module mat_frame_loader (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [15:0]  in_data,
  input  logic [2:0]   in_choice,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] A,
  output logic [255:0] B,
  output logic [2:0]   choice,
  output logic         frame_err
);

  // Handshakes: a word moves when in_valid & in_ready at a rising edge;
  // a frame moves when out_valid & out_ready at a rising edge.
  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [255:0]   a_q, a_d;
  logic [255:0]   b_q, b_d;
  logic [2:0]     choice_q, choice_d;
  logic           err_q, err_d;
  logic           accept;

  assign in_ready  = ~rst & (state_q != HOLD);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == HOLD);
  assign A         = a_q;
  assign B         = b_q;
  assign choice    = choice_q;
  assign frame_err = err_q;

`ifndef MAT_FRAME_LOADER_CHK_EN
  logic unused_in_last;
  assign unused_in_last = in_last;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    choice_d = choice_q;
    err_d    = 1'b0;
    case (state_q)
      LOAD_A: begin
        if (accept) begin
          // Element 0 lands in the top slice, so index e maps to [255-16e -: 16].
          for (int e = 0; e < 16; e++) begin
            if (idx_q == 4'(e)) a_d[255-16*e -: 16] = in_data;
          end
          if (idx_q == 4'd0) choice_d = in_choice;
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (accept) begin
          for (int e = 0; e < 16; e++) begin
            if (idx_q == 4'(e)) b_d[255-16*e -: 16] = in_data;
          end
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = LOAD_A;
      end
      default: begin
        state_d = LOAD_A;
        idx_d   = 4'd0;
      end
    endcase
`ifdef MAT_FRAME_LOADER_CHK_EN
    // An early end marker aborts the frame; a missing one on word 32 is only flagged.
    if (accept) begin
      if ((state_q == LOAD_B) && (idx_q == 4'd15)) begin
        if (!in_last) err_d = 1'b1;
      end else if (in_last) begin
        err_d   = 1'b1;
        state_d = LOAD_A;
        idx_d   = 4'd0;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LOAD_A;
      idx_q    <= 4'd0;
      a_q      <= '0;
      b_q      <= '0;
      choice_q <= 3'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      choice_q <= choice_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mat_frame_loader.sv
// Directed bench for mat_frame_loader with a frame scoreboard; define MAT_FRAME_LOADER_CHK_EN to add framing-check steps.
module tb_mat_frame_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_data;
  logic [2:0]   in_choice;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] A;
  logic [255:0] B;
  logic [2:0]   choice;
  logic         frame_err;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0]  fw [32];
  logic [255:0] exp_a_q [$];
  logic [255:0] exp_b_q [$];
  logic [2:0]   exp_ch_q [$];
  logic [255:0] hold_a;

  mat_frame_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_choice (in_choice),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A         (A),
    .B         (B),
    .choice    (choice),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] d, input logic [2:0] ch, input logic last);
    int waitc;
    waitc = 0;
    in_data   = d;
    in_choice = ch;
    in_last   = last;
    in_valid  = 1'b1;
    while (!in_ready && waitc < 200) begin
      tick();
      waitc++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout observed=in_ready_low expected=in_ready_high");
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push_expected(input logic [2:0] ch);
    logic [255:0] ea, eb;
    ea = '0;
    eb = '0;
    for (int e = 0; e < 16; e++) begin
      ea[255-16*e -: 16] = fw[e];
      eb[255-16*e -: 16] = fw[16+e];
    end
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
    exp_ch_q.push_back(ch);
  endtask

  task automatic send_frame(input logic [2:0] ch, input int gap_max, input logic last_ok);
    push_expected(ch);
    for (int i = 0; i < 32; i++) begin
      send_word(fw[i], ch, (i == 31) ? last_ok : 1'b0);
      if (gap_max > 0 && i != 31) repeat ($urandom_range(0, gap_max)) tick();
    end
  endtask

  // Frame scoreboard: compares when the output handshake is about to complete.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_a_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected observed=out_valid expected=no_frame");
      end else begin
        chk("sb_A", A, exp_a_q.pop_front());
        chk("sb_B", B, exp_b_q.pop_front());
        chk("sb_choice", {253'd0, choice}, {253'd0, exp_ch_q.pop_front()});
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_choice = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_A", A, '0);
    chk("rst_B", B, '0);
    chk("rst_choice", {253'd0, choice}, '0);
    chk("rst_out_valid", {255'd0, out_valid}, '0);
    chk("rst_in_ready", {255'd0, in_ready}, '0);
    chk("rst_frame_err", {255'd0, frame_err}, '0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", {255'd0, in_ready}, 256'd1);

    // Back-to-back frame 1..32, downstream always ready.
    for (int i = 0; i < 32; i++) fw[i] = 16'(i + 1);
    out_ready = 1'b1;
    send_frame(3'b010, 0, 1'b1);
    chk("t1_out_valid", {255'd0, out_valid}, 256'd1);
    chk("t1_in_ready_hold", {255'd0, in_ready}, '0);
    chk("t1_A00", {240'd0, A[255:240]}, 256'd1);
    chk("t1_A33", {240'd0, A[15:0]}, 256'd16);
    chk("t1_B00", {240'd0, B[255:240]}, 256'd17);
    chk("t1_B33", {240'd0, B[15:0]}, 256'd32);
    chk("t1_choice", {253'd0, choice}, 256'd2);
    tick();
    chk("t1_out_valid_fall", {255'd0, out_valid}, '0);
    chk("t1_in_ready_rise", {255'd0, in_ready}, 256'd1);

    // Back-pressure: frame held for 10 cycles while upstream keeps pushing.
    out_ready = 1'b0;
    send_frame(3'b010, 0, 1'b1);
    hold_a = A;
    in_valid = 1'b1;
    in_data = 16'hDEAD;
    for (int k = 0; k < 10; k++) begin
      chk("t2_out_valid_held", {255'd0, out_valid}, 256'd1);
      chk("t2_in_ready_low", {255'd0, in_ready}, '0);
      chk("t2_A_stable", A, hold_a);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t2_out_valid_fall", {255'd0, out_valid}, '0);
    chk("t2_in_ready_rise", {255'd0, in_ready}, 256'd1);

    // Sign extremes in B element 0 and 15.
    for (int i = 0; i < 32; i++) fw[i] = 16'($urandom_range(0, 65535));
    fw[16] = 16'hFFFF;
    fw[31] = 16'h8000;
    send_frame(3'b101, 0, 1'b1);
    chk("t3_B00_neg1", {240'd0, B[255:240]}, 256'h0FFFF);
    chk("t3_B33_min", {240'd0, B[15:0]}, 256'h08000);
    tick();

    // Random upstream gaps on the reference frame.
    for (int i = 0; i < 32; i++) fw[i] = 16'(i + 1);
    send_frame(3'b010, 3, 1'b1);
    chk("t4_out_valid", {255'd0, out_valid}, 256'd1);
    tick();

    // Reset after 20 words, then a clean new frame.
    for (int i = 0; i < 20; i++) send_word(16'(16'h7000 + i), 3'b111, 1'b0);
    rst = 1'b1;
    #1;
    chk("t5_rst_A", A, '0);
    chk("t5_rst_B", B, '0);
    chk("t5_rst_out_valid", {255'd0, out_valid}, '0);
    chk("t5_rst_in_ready", {255'd0, in_ready}, '0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 32; i++) fw[i] = 16'(16'h0100 + i);
    send_frame(3'b001, 1, 1'b1);
    chk("t5_out_valid", {255'd0, out_valid}, 256'd1);
    tick();

`ifdef MAT_FRAME_LOADER_CHK_EN
    // Early end marker on word 10 aborts the frame.
    for (int i = 0; i < 10; i++) send_word(16'(16'h0A00 + i), 3'b011, (i == 9));
    chk("t6_err_pulse", {255'd0, frame_err}, 256'd1);
    chk("t6_no_out_valid", {255'd0, out_valid}, '0);
    tick();
    chk("t6_err_clear", {255'd0, frame_err}, '0);
    for (int i = 0; i < 32; i++) fw[i] = 16'(16'h0200 + i);
    send_frame(3'b100, 0, 1'b1);
    chk("t6_clean_out_valid", {255'd0, out_valid}, 256'd1);
    chk("t6_clean_no_err", {255'd0, frame_err}, '0);
    tick();
    // Missing end marker on word 32 is flagged but the frame completes.
    for (int i = 0; i < 32; i++) fw[i] = 16'(16'h0300 + i);
    send_frame(3'b110, 0, 1'b0);
    chk("t7_err_pulse", {255'd0, frame_err}, 256'd1);
    chk("t7_out_valid", {255'd0, out_valid}, 256'd1);
    tick();
    chk("t7_err_clear", {255'd0, frame_err}, '0);
`else
    chk("no_chk_frame_err", {255'd0, frame_err}, '0);
`endif

    repeat (2) tick();
    chk("sb_drained", 256'(exp_a_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
